// File: rtl/afu_req_pkg.sv
// afu_req_pkg: shared error-bit indices and request record layouts for the
// AFU request queue. The record widths follow the package constants below;
// afu_req_queue parameter defaults are taken from the same constants.
package afu_req_pkg;

   localparam int AFU_ADDR_LMT    = 20;
   localparam int AFU_MDATA       = 14;
   localparam int AFU_CACHE_WIDTH = 512;

   // Sticky error bit positions in afu_req_queue.err
   localparam int ERR_RD_OVF = 0;
   localparam int ERR_WR_OVF = 1;
   localparam int ERR_SPUR   = 2;

   typedef struct packed {
      logic [AFU_ADDR_LMT-1:0] addr;
      logic [AFU_MDATA-1:0]    mdata;
   } rd_req_t;

   typedef struct packed {
      logic [AFU_ADDR_LMT-1:0]    addr;
      logic [AFU_MDATA-1:0]       mdata;
      logic [AFU_CACHE_WIDTH-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/afu_req_fifo.sv
// afu_req_fifo: small synchronous FIFO with show-ahead head output.
// A push while full is accepted only if a pop happens in the same cycle.
module afu_req_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
      end
   end

   // Storage array; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/afu_req_queue.sv
// afu_req_queue: buffers AFU read/write requests, issues them to CCI under
// almost-full back-pressure and a per-channel outstanding credit limit,
// tracks outstanding responses, and reports idle / sticky error status.
// Optional: define AFU_REQ_ORDER_EN to hold writes until the read FIFO is
// empty and no reads are outstanding (read-before-write fence).
module afu_req_queue
   import afu_req_pkg::*;
#(
   parameter int ADDR_LMT        = AFU_ADDR_LMT,
   parameter int MDATA           = AFU_MDATA,
   parameter int CACHE_WIDTH     = AFU_CACHE_WIDTH,
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [ADDR_LMT-1:0]                      rd_req_addr,
   input  logic [MDATA-1:0]                         rd_req_mdata,
   input  logic                                     rd_req_en,
   output logic                                     rd_req_almostfull,
   input  logic [ADDR_LMT-1:0]                      wr_req_addr,
   input  logic [MDATA-1:0]                         wr_req_mdata,
   input  logic [CACHE_WIDTH-1:0]                   wr_req_data,
   input  logic                                     wr_req_en,
   output logic                                     wr_req_almostfull,
   output logic [ADDR_LMT-1:0]                      cci_rd_addr,
   output logic [MDATA-1:0]                         cci_rd_mdata,
   output logic                                     cci_rd_valid,
   input  logic                                     cci_rd_almostfull,
   output logic [ADDR_LMT-1:0]                      cci_wr_addr,
   output logic [MDATA-1:0]                         cci_wr_mdata,
   output logic [CACHE_WIDTH-1:0]                   cci_wr_data,
   output logic                                     cci_wr_valid,
   input  logic                                     cci_wr_almostfull,
   input  logic                                     cci_rd_rsp_valid,
   input  logic                                     cci_wr_rsp0_valid,
   input  logic                                     cci_wr_rsp1_valid,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     rd_outstanding,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     wr_outstanding,
   output logic                                     idle,
   output logic [2:0]                               err
);

   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int CW = FIFO_DEPTH_LOG2 + 1;
   localparam int D  = 1 << FIFO_DEPTH_LOG2;

   rd_req_t        rd_in, rd_head;
   wr_req_t        wr_in, wr_head;
   logic [CW-1:0]  rd_count, wr_count;
   logic           rd_empty, rd_full, wr_empty, wr_full;
   logic           rd_issue, wr_issue;
   logic           rd_ovf, wr_ovf;
   logic [OW:0]    rd_sum, wr_sum, rd_dec, wr_dec;
   logic           rd_under, wr_under;
   logic [OW-1:0]  rd_out_nxt, wr_out_nxt;

   assign rd_in = '{addr: rd_req_addr, mdata: rd_req_mdata};
   assign wr_in = '{addr: wr_req_addr, mdata: wr_req_mdata, data: wr_req_data};

   afu_req_fifo #(.WIDTH($bits(rd_req_t)), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rd_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rd_req_en),
      .pop   (rd_issue),
      .din   (rd_in),
      .dout  (rd_head),
      .count (rd_count),
      .empty (rd_empty),
      .full  (rd_full)
   );

   afu_req_fifo #(.WIDTH($bits(wr_req_t)), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_wr_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_req_en),
      .pop   (wr_issue),
      .din   (wr_in),
      .dout  (wr_head),
      .count (wr_count),
      .empty (wr_empty),
      .full  (wr_full)
   );

   assign rd_req_almostfull = (rd_count >= CW'(D-1));
   assign wr_req_almostfull = (wr_count >= CW'(D-1));

   // A same-cycle pop frees a slot, so only an enqueue into a full FIFO
   // with no issue that cycle is lost.
   assign rd_ovf = rd_req_en && rd_full && !rd_issue;
   assign wr_ovf = wr_req_en && wr_full && !wr_issue;

   assign rd_issue = !rd_empty && !cci_rd_almostfull && (rd_outstanding < OW'(MAX_OUTSTANDING));
`ifdef AFU_REQ_ORDER_EN
   assign wr_issue = !wr_empty && !cci_wr_almostfull && (wr_outstanding < OW'(MAX_OUTSTANDING))
                     && rd_empty && (rd_outstanding == '0);
`else
   assign wr_issue = !wr_empty && !cci_wr_almostfull && (wr_outstanding < OW'(MAX_OUTSTANDING));
`endif

   // Net outstanding update; a decrement past zero saturates and flags spurious
   always_comb begin
      rd_sum     = {1'b0, rd_outstanding} + (OW+1)'(rd_issue);
      wr_sum     = {1'b0, wr_outstanding} + (OW+1)'(wr_issue);
      rd_dec     = (OW+1)'(cci_rd_rsp_valid);
      wr_dec     = (OW+1)'(cci_wr_rsp0_valid) + (OW+1)'(cci_wr_rsp1_valid);
      rd_under   = (rd_sum < rd_dec);
      wr_under   = (wr_sum < wr_dec);
      rd_out_nxt = rd_under ? '0 : OW'(rd_sum - rd_dec);
      wr_out_nxt = wr_under ? '0 : OW'(wr_sum - wr_dec);
   end

   // Issue registers: one-cycle valid pulse, fields hold between issues
   always_ff @(posedge clk) begin
      if (reset) begin
         cci_rd_valid <= 1'b0;
         cci_rd_addr  <= '0;
         cci_rd_mdata <= '0;
         cci_wr_valid <= 1'b0;
         cci_wr_addr  <= '0;
         cci_wr_mdata <= '0;
         cci_wr_data  <= '0;
      end else begin
         cci_rd_valid <= rd_issue;
         cci_wr_valid <= wr_issue;
         if (rd_issue) begin
            cci_rd_addr  <= rd_head.addr;
            cci_rd_mdata <= rd_head.mdata;
         end
         if (wr_issue) begin
            cci_wr_addr  <= wr_head.addr;
            cci_wr_mdata <= wr_head.mdata;
            cci_wr_data  <= wr_head.data;
         end
      end
   end

   // Outstanding counters, sticky errors and registered idle status
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_outstanding <= '0;
         wr_outstanding <= '0;
         err            <= '0;
         idle           <= 1'b1;
      end else begin
         rd_outstanding <= rd_out_nxt;
         wr_outstanding <= wr_out_nxt;
         err[ERR_RD_OVF] <= err[ERR_RD_OVF] | rd_ovf;
         err[ERR_WR_OVF] <= err[ERR_WR_OVF] | wr_ovf;
         err[ERR_SPUR]   <= err[ERR_SPUR] | rd_under | wr_under;
         idle <= rd_empty && wr_empty && (rd_outstanding == '0) && (wr_outstanding == '0)
                 && !cci_rd_valid && !cci_wr_valid;
      end
   end

endmodule

// File: tb/tb_afu_req_queue.sv
// tb_afu_req_queue: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based transaction model of the request shim.
module tb_afu_req_queue;

   localparam int AL = 20, MD = 14, CW = 512, DL2 = 2, D = 4, MAXO = 3;
   localparam int OW = $clog2(MAXO+1);

   logic clk = 0, reset = 1;
   logic [AL-1:0] rd_req_addr = '0, wr_req_addr = '0;
   logic [MD-1:0] rd_req_mdata = '0, wr_req_mdata = '0;
   logic [CW-1:0] wr_req_data = '0;
   logic rd_req_en = 0, wr_req_en = 0;
   logic cci_rd_almostfull = 0, cci_wr_almostfull = 0;
   logic cci_rd_rsp_valid = 0, cci_wr_rsp0_valid = 0, cci_wr_rsp1_valid = 0;
   logic rd_req_almostfull, wr_req_almostfull, cci_rd_valid, cci_wr_valid, idle;
   logic [AL-1:0] cci_rd_addr, cci_wr_addr;
   logic [MD-1:0] cci_rd_mdata, cci_wr_mdata;
   logic [CW-1:0] cci_wr_data;
   logic [OW-1:0] rd_outstanding, wr_outstanding;
   logic [2:0] err;

   afu_req_queue #(.ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(CW),
                   .FIFO_DEPTH_LOG2(DL2), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .reset(reset),
      .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
      .rd_req_almostfull(rd_req_almostfull),
      .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
      .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
      .cci_rd_addr(cci_rd_addr), .cci_rd_mdata(cci_rd_mdata), .cci_rd_valid(cci_rd_valid),
      .cci_rd_almostfull(cci_rd_almostfull),
      .cci_wr_addr(cci_wr_addr), .cci_wr_mdata(cci_wr_mdata), .cci_wr_data(cci_wr_data),
      .cci_wr_valid(cci_wr_valid), .cci_wr_almostfull(cci_wr_almostfull),
      .cci_rd_rsp_valid(cci_rd_rsp_valid), .cci_wr_rsp0_valid(cci_wr_rsp0_valid),
      .cci_wr_rsp1_valid(cci_wr_rsp1_valid),
      .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
      .idle(idle), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0, passes = 0;

   task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---- transaction model ----
   typedef struct {
      logic [AL-1:0] addr;
      logic [MD-1:0] mdata;
      logic [CW-1:0] data;
   } mreq_t;

   mreq_t rdq[$], wrq[$];
   mreq_t m_rcur, m_wcur;
   int    m_rd_out, m_wr_out;
   logic  m_rv, m_wv, m_idle;
   logic [2:0] m_err;

   task automatic model_reset();
      rdq.delete(); wrq.delete();
      m_rcur = '{default: '0}; m_wcur = '{default: '0};
      m_rd_out = 0; m_wr_out = 0;
      m_rv = 0; m_wv = 0; m_idle = 1; m_err = '0;
   endtask

   task automatic model_cycle();
      bit ri, wi, nidle;
      int t;
      mreq_t r;
      ri = (rdq.size() > 0) && !cci_rd_almostfull && (m_rd_out < MAXO);
      wi = (wrq.size() > 0) && !cci_wr_almostfull && (m_wr_out < MAXO);
`ifdef AFU_REQ_ORDER_EN
      wi = wi && (rdq.size() == 0) && (m_rd_out == 0);
`endif
      nidle = (rdq.size() == 0) && (wrq.size() == 0) && (m_rd_out == 0) && (m_wr_out == 0)
              && !m_rv && !m_wv;
      m_rv = ri; m_wv = wi;
      if (ri) m_rcur = rdq.pop_front();
      if (wi) m_wcur = wrq.pop_front();
      if (rd_req_en) begin
         r = '{addr: rd_req_addr, mdata: rd_req_mdata, data: '0};
         if (rdq.size() < D) rdq.push_back(r); else m_err[0] = 1'b1;
      end
      if (wr_req_en) begin
         r = '{addr: wr_req_addr, mdata: wr_req_mdata, data: wr_req_data};
         if (wrq.size() < D) wrq.push_back(r); else m_err[1] = 1'b1;
      end
      t = m_rd_out + int'(ri) - int'(cci_rd_rsp_valid);
      if (t < 0) begin t = 0; m_err[2] = 1'b1; end
      m_rd_out = t;
      t = m_wr_out + int'(wi) - int'(cci_wr_rsp0_valid) - int'(cci_wr_rsp1_valid);
      if (t < 0) begin t = 0; m_err[2] = 1'b1; end
      m_wr_out = t;
      m_idle = nidle;
   endtask

   task automatic compare_all();
      chk("rd_valid", cci_rd_valid, m_rv);
      chk("rd_addr", cci_rd_addr, m_rcur.addr);
      chk("rd_mdata", cci_rd_mdata, m_rcur.mdata);
      chk("wr_valid", cci_wr_valid, m_wv);
      chk("wr_addr", cci_wr_addr, m_wcur.addr);
      chk("wr_mdata", cci_wr_mdata, m_wcur.mdata);
      chk("wr_data", cci_wr_data, m_wcur.data);
      chk("rd_af", rd_req_almostfull, rdq.size() >= D-1);
      chk("wr_af", wr_req_almostfull, wrq.size() >= D-1);
      chk("rd_out", rd_outstanding, m_rd_out);
      chk("wr_out", wr_outstanding, m_wr_out);
      chk("idle", idle, m_idle);
      chk("err", err, m_err);
   endtask

   // One clock: model consumes current inputs, DUT samples them at the edge,
   // outputs compared 1 time unit later; strobes then drop.
   task automatic step();
      if (reset) model_reset(); else model_cycle();
      @(posedge clk);
      #1;
      compare_all();
      rd_req_en = 0; wr_req_en = 0;
      cci_rd_rsp_valid = 0; cci_wr_rsp0_valid = 0; cci_wr_rsp1_valid = 0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      reset = 1; step(); reset = 0;
   endtask

   task automatic rd_enq(input logic [AL-1:0] a, input logic [MD-1:0] m);
      rd_req_addr = a; rd_req_mdata = m; rd_req_en = 1;
   endtask

   task automatic wr_enq(input logic [AL-1:0] a, input logic [MD-1:0] m, input logic [CW-1:0] d);
      wr_req_addr = a; wr_req_mdata = m; wr_req_data = d; wr_req_en = 1;
   endtask

   function automatic logic [CW-1:0] rnd_data();
      logic [CW-1:0] d;
      for (int i = 0; i < CW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   initial begin
      model_reset();
      #2;
      steps(2);
      chk("reset_idle", idle, 1'b1);
      chk("reset_err", err, 3'b000);
      reset = 0;

      // single read: issue two cycles after enqueue, response clears credit
      steps(7);
      rd_enq(20'h5, 14'h0); step();
      step();
      chk("rd_latency_valid", cci_rd_valid, 1'b1);
      chk("rd_latency_addr", cci_rd_addr, 20'h5);
      steps(2);
      cci_rd_rsp_valid = 1; step();
      chk("rd_rsp_out", rd_outstanding, 0);
      steps(3);

      // back-pressure then credit limit (MAXO reads issue, next waits for a response)
      cci_rd_almostfull = 1;
      for (int i = 0; i < 4; i++) begin rd_enq(20'h10 + i, 14'(i)); step(); end
      steps(2);
      cci_rd_almostfull = 0;
      steps(6);
      cci_rd_rsp_valid = 1; step();
      steps(3);
      for (int i = 0; i < 3; i++) begin cci_rd_rsp_valid = 1; step(); end
      steps(2);

      // overflow: fifth enqueue dropped, then addrs 0..3 drain in order
      do_reset();
      cci_rd_almostfull = 1;
      for (int i = 0; i < 5; i++) begin rd_enq(AL'(i), 14'h0); step(); end
      chk("ovf_err", err, 3'b001);
      cci_rd_almostfull = 0;
      steps(4);
      for (int i = 0; i < 4; i++) begin cci_rd_rsp_valid = 1; step(); end
      steps(3);

      // dual write response then a spurious one
      do_reset();
      wr_enq(20'hA, 14'h1, rnd_data()); step();
      wr_enq(20'hB, 14'h2, rnd_data()); step();
      steps(3);
      chk("wr_out_two", wr_outstanding, 2);
      cci_wr_rsp0_valid = 1; cci_wr_rsp1_valid = 1; step();
      chk("wr_out_zero", wr_outstanding, 0);
      cci_wr_rsp0_valid = 1; step();
      chk("spur_err", err[2], 1'b1);
      steps(2);

      // reset mid-flight discards state; late response is spurious
      do_reset();
      rd_enq(20'h21, 14'h3); step();
      rd_enq(20'h22, 14'h4); step();
      cci_wr_almostfull = 1;
      wr_enq(20'h31, 14'h5, rnd_data()); step();
      steps(2);
      reset = 1; step(); reset = 0;
      chk("mid_reset_idle", idle, 1'b1);
      chk("mid_reset_rdout", rd_outstanding, 0);
      cci_wr_almostfull = 0;
      steps(2);
      cci_rd_rsp_valid = 1; step();
      chk("late_rsp_err", err, 3'b100);
      steps(2);

      // read then write, read response delayed 6 cycles
      do_reset();
      rd_enq(20'h40, 14'h6); step();
      wr_enq(20'h41, 14'h7, rnd_data()); step();
      steps(6);
      cci_rd_rsp_valid = 1; step();
      steps(4);
      cci_wr_rsp0_valid = 1; step();
      steps(2);

      // randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         if (c % 600 == 0) begin reset = 1; step(); reset = 0; end
         cci_rd_almostfull = ($urandom_range(0, 3) == 0);
         cci_wr_almostfull = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 2) != 0) rd_enq(AL'($urandom), MD'($urandom));
         if ($urandom_range(0, 2) != 0) wr_enq(AL'($urandom), MD'($urandom), rnd_data());
         cci_rd_rsp_valid  = ((m_rd_out > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 299) == 0);
         cci_wr_rsp0_valid = ((m_wr_out > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 299) == 0);
         cci_wr_rsp1_valid = ((m_wr_out > 1) && ($urandom_range(0, 3) == 0));
         step();
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/afu_req_queue.md
Name: afu_req_queue

Overview:
- Request-side shim directly downstream of the AFU user datapath and upstream of the CCI channel interface.
- Buffers read and write requests in two small FIFOs and issues them onto the CCI read/write channels, honouring CCI almost-full.
- Enforces a per-channel outstanding-request credit limit and counts outstanding requests until their responses return.
- Raises almost-full back to the datapath, and reports idle and sticky error status.

Parameters:
- ADDR_LMT, 20, cache-line address width
- MDATA, 14, request/response metadata width
- CACHE_WIDTH, 512, write data width
- FIFO_DEPTH_LOG2, 2, log2 of each request FIFO depth (depth D = 4)
- MAX_OUTSTANDING, 8, maximum issued-but-unanswered requests per channel (≥1)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- rd_req_addr  in  ADDR_LMT  read address from datapath
- rd_req_mdata  in  MDATA  read metadata
- rd_req_en  in  1  read enqueue strobe
- rd_req_almostfull  out  1  read FIFO almost full
- wr_req_addr  in  ADDR_LMT  write address
- wr_req_mdata  in  MDATA  write metadata
- wr_req_data  in  CACHE_WIDTH  write data
- wr_req_en  in  1  write enqueue strobe
- wr_req_almostfull  out  1  write FIFO almost full
- cci_rd_addr / cci_rd_mdata  out  ADDR_LMT / MDATA  issued read request fields
- cci_rd_valid  out  1  read issue pulse
- cci_rd_almostfull  in  1  CCI read channel back-pressure
- cci_wr_addr / cci_wr_mdata / cci_wr_data  out  ADDR_LMT / MDATA / CACHE_WIDTH  issued write request fields
- cci_wr_valid  out  1  write issue pulse
- cci_wr_almostfull  in  1  CCI write channel back-pressure
- cci_rd_rsp_valid  in  1  read response returned
- cci_wr_rsp0_valid, cci_wr_rsp1_valid  in  1 each  write responses, up to two per cycle
- rd_outstanding, wr_outstanding  out  $clog2(MAX_OUTSTANDING+1)  credits in use
- idle  out  1  nothing buffered or outstanding
- err  out  3  sticky errors: [0] rd overflow, [1] wr overflow, [2] spurious response

Behaviour:
- Reset (synchronous, active-high):
  - FIFOs emptied; counters cleared.
  - All cci_*_valid = 0 and all issued address/mdata/data outputs = 0.
  - err = 0, idle = 1, almostfull outputs = 0.
  - A reset asserted mid-operation discards all buffered and outstanding state; later responses for pre-reset requests are counted as spurious.
- Enqueue: on *_req_en, the request is written to its FIFO at that clock edge.
- Almost full: *_req_almostfull = (FIFO count ≥ D-1), combinational from the registered count.
- Overflow: an enqueue while the FIFO holds D entries is dropped and sets the matching err bit.
- Issue (per channel, independent, at most one per cycle), when all of the following hold in cycle N:
  - the FIFO is non-empty,
  - !cci_*_almostfull,
  - outstanding < MAX_OUTSTANDING.
- Issue action:
  - pop the head;
  - register its fields onto cci_* with cci_*_valid = 1 during cycle N+1;
  - valid is a one-cycle pulse; fields hold their last value otherwise.
- Latency: rd_req_en at edge E gives the earliest cci_rd_valid in the cycle after edge E+1 (2 cycles). Writes are the same.
- Simultaneous enqueue and pop on a full FIFO:
  - the pop frees a slot, so the enqueue is accepted;
  - no overflow;
  - count unchanged.
- Outstanding counters:
  - +1 on issue;
  - -1 per response (cci_rd_rsp_valid; each of wr_rsp0/wr_rsp1, so -2 when both are high);
  - net change applied when increment and decrement happen in the same cycle.
- Spurious response: any decrement that would drop a counter below 0 saturates at 0 and sets err[2].
- Credit limit: with outstanding = MAX, no issue occurs; a response in cycle N permits an issue in cycle N+1.
- idle = both FIFOs empty, both counters 0, no cci_*_valid asserted. Registered.
- err bits clear only on reset.

Optional Feature:
- Macro AFU_REQ_ORDER_EN.
- Defined: a write may issue only when the read FIFO is empty and rd_outstanding = 0. This is a read-before-write fence.
- Undefined: the read and write channels issue fully independently.

Decomposition:
- Package afu_req_pkg holds:
  - the error bit index constants (ERR_RD_OVF=0, ERR_WR_OVF=1, ERR_SPUR=2);
  - the rd/wr request struct typedefs (addr, mdata, data) sized from the parameters.
- Sub-module afu_req_fifo:
  - generic synchronous FIFO with width and depth parameters;
  - outputs count, empty, full;
  - instantiated twice: read width ADDR_LMT+MDATA, write width ADDR_LMT+MDATA+CACHE_WIDTH.

Test Plan:
- Single read: rd_req_en at edge 10, addr 0x5, mdata 0x0 → cci_rd_valid high in the cycle after edge 11 with addr 0x5. rd_outstanding goes 1, then returns to 0 one cycle after cci_rd_rsp_valid. idle returns to 1.
- Back-pressure and credit limit:
  - hold cci_rd_almostfull = 1 and enqueue 3 reads → rd_req_almostfull = 1 at count 3, no issue;
  - release → 3 issues on consecutive cycles;
  - with MAX_OUTSTANDING = 2, only 2 issue until one response arrives.
- Overflow: 5 consecutive rd_req_en with issue blocked → 5th dropped, err = 3'b001. The FIFO then delivers exactly addrs 0..3 in order.
- Dual write response: issue 2 writes, then pulse wr_rsp0 and wr_rsp1 together → wr_outstanding goes 2 → 0 in one cycle. An extra wr_rsp0 afterwards → err[2] = 1, counter stays 0.
- Reset mid-flight: 2 reads outstanding and 1 buffered write, assert reset for 1 cycle → all outputs at reset values, idle = 1. A later cci_rd_rsp_valid sets err[2].
- With AFU_REQ_ORDER_EN: enqueue a read then a write with the read response delayed 6 cycles → cci_wr_valid asserts only after rd_outstanding returns to 0. Without the macro, the write issues 2 cycles after its enqueue.
